// File: rtl/axis_fifo_pkg_prm.sv
// Shared parameters and types for the AXI-Stream FIFO and its traffic sources.
package axis_fifo_pkg_prm;

    localparam int unsigned AXI_DATA_WIDTH  = 32;
    localparam int unsigned BURST_LEN_WIDTH = 16;
    localparam int unsigned GAP_WIDTH       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } gen_state_t;

    // Data word for a given beat index: seed plus index, wrapping at the data width.
    function automatic logic [AXI_DATA_WIDTH-1:0] beat_data(
        input logic [AXI_DATA_WIDTH-1:0]  seed_val,
        input logic [BURST_LEN_WIDTH-1:0] idx
    );
        return seed_val + AXI_DATA_WIDTH'(idx);
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream link bundle; one instance connects a master to a slave.
interface axis_if;
    import axis_fifo_pkg_prm::*;

    logic [AXI_DATA_WIDTH-1:0] tdata;
    logic                      tvalid;
    logic                      tready;

    modport m_axis (output tdata, output tvalid, input tready);
    modport s_axis (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_pattern_gen.sv
// AXI-Stream burst source: emits seed, seed+1, ... for burst_len beats, then an
// optional idle gap and a one-cycle done pulse.
module axis_pattern_gen
    import axis_fifo_pkg_prm::*;
(
    input  logic                       aclk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    input  logic [GAP_WIDTH-1:0]       gap_len,
    input  logic [AXI_DATA_WIDTH-1:0]  seed,
    output logic                       busy,
    output logic                       done,
    axis_if.m_axis                     m_axis
);

    gen_state_t                 state;
    logic [BURST_LEN_WIDTH-1:0] len_q;
    logic [GAP_WIDTH-1:0]       gap_q;
    logic [AXI_DATA_WIDTH-1:0]  seed_q;
    logic [BURST_LEN_WIDTH-1:0] beat_cnt;
    logic [GAP_WIDTH-1:0]       gap_cnt;
    logic                       tvalid_q;
    logic [AXI_DATA_WIDTH-1:0]  tdata_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       last_beat;

    // Beat counter holds the current index (max burst_len-1), so it never wraps
    // before the compare even for the largest burst length.
    assign last_beat = (beat_cnt == (len_q - BURST_LEN_WIDTH'(1)));

    // Burst sequencer with registered stream and status outputs.
    always_ff @(posedge aclk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            gap_q    <= '0;
            seed_q   <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= burst_len;
                        gap_q    <= gap_len;
                        seed_q   <= seed;
                        beat_cnt <= '0;
                        busy_q   <= 1'b1;
                        if (burst_len != '0) begin
                            state    <= SEND;
                            tvalid_q <= 1'b1;
                            tdata_q  <= seed;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (tvalid_q && m_axis.tready) begin
                        if (last_beat) begin
                            tvalid_q <= 1'b0;
                            if (gap_q != '0) begin
                                state   <= GAP;
                                gap_cnt <= gap_q;
                            end else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BURST_LEN_WIDTH'(1);
                            tdata_q  <= beat_data(seed_q, beat_cnt + BURST_LEN_WIDTH'(1));
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    tvalid_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
